// File: rtl/osc_period_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// osc_period_sweep_ctrl
//   Sequences the clock-enable period word of an oscillator to produce linear
//   frequency sweeps. The period steps from a start value to an end value by a
//   fixed increment. Each value is held for a programmable number of system
//   clocks. At the end of a sweep the block either stops (one-shot), restarts
//   (repeat) or reverses direction (ping-pong).
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   cr_start          pulse: begin a sweep (only honoured while idle)
//   cr_stop           pulse: abort the sweep, period_out keeps its value
//   cr_mode           0 one-shot, 1 repeat, 2 ping-pong, 3 behaves as 0
//   cr_period_start   first period of the sweep
//   cr_period_end     last period of the sweep
//   cr_period_step    magnitude of each period change
//   cr_dwell_cycles   clocks each period is held (0 behaves as 1)
//   period_out        period word to the oscillator's cr_clock_enable
//   period_update     one-cycle pulse when period_out changes or is reloaded
//   sweep_busy        high while a sweep is running
//   sweep_done        one-cycle pulse when a one-shot sweep completes
// ----------------------------------------------------------------------------
module osc_period_sweep_ctrl #(
  parameter int COUNTER_WIDTH_P = 28,
  parameter int DWELL_WIDTH_P   = 32,
  parameter logic [COUNTER_WIDTH_P-1:0] DEFAULT_PERIOD_P =
    {{(COUNTER_WIDTH_P-1){1'b0}}, 1'b1}
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cr_start,
  input  logic                       cr_stop,
  input  logic [1:0]                 cr_mode,
  input  logic [COUNTER_WIDTH_P-1:0] cr_period_start,
  input  logic [COUNTER_WIDTH_P-1:0] cr_period_end,
  input  logic [COUNTER_WIDTH_P-1:0] cr_period_step,
  input  logic [DWELL_WIDTH_P-1:0]   cr_dwell_cycles,
  output logic [COUNTER_WIDTH_P-1:0] period_out,
  output logic                       period_update,
  output logic                       sweep_busy,
  output logic                       sweep_done
);

  localparam int CW = COUNTER_WIDTH_P;
  localparam int DW = DWELL_WIDTH_P;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DWELL,
    ST_STEP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_period;
  logic            r_update;
  logic            r_busy;
  logic            r_done;
  logic [DW-1:0]   r_cnt;
  // Shadow copies of the configuration, frozen at sweep start.
  logic [1:0]      r_mode;
  logic [CW-1:0]   r_start;
  logic [CW-1:0]   r_end;
  logic [CW-1:0]   r_step;
  logic [DW-1:0]   r_dwell;
  logic            r_dir_up;

  logic [CW-1:0]   w_step_next;
  logic [CW-1:0]   w_pp_next;
  logic [DW-1:0]   w_reload;
  logic [DW-1:0]   w_start_reload;
  logic            w_at_end;

  // Move cur by step towards target in CW+1 bits, clamping to target on
  // overshoot. The extra bit catches both wrap below zero and carry-out.
  function automatic logic [CW-1:0] f_next(input logic [CW-1:0] cur,
                                           input logic [CW-1:0] step,
                                           input logic [CW-1:0] target,
                                           input logic          up);
    logic [CW:0] sum;
    if (up) begin
      sum = {1'b0, cur} + {1'b0, step};
      if (sum > {1'b0, target}) sum = {1'b0, target};
    end else begin
      sum = {1'b0, cur} - {1'b0, step};
      if (sum[CW] || (sum < {1'b0, target})) sum = {1'b0, target};
    end
    return sum[CW-1:0];
  endfunction

  // Counter load value for a dwell of d clocks; 0 is treated as 1.
  function automatic logic [DW-1:0] f_reload(input logic [DW-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  assign w_step_next    = f_next(r_period, r_step, r_end, r_dir_up);
  // Ping-pong turnaround: first step away from the old end towards old start.
  assign w_pp_next      = f_next(r_end, r_step, r_start, ~r_dir_up);
  assign w_reload       = f_reload(r_dwell);
  assign w_start_reload = f_reload(cr_dwell_cycles);
  assign w_at_end       = (r_period == r_end);

  // The STEP cycle is the last cycle of the current dwell window, so a value
  // is held exactly max(dwell,1) clocks. A one-clock dwell therefore goes
  // straight back to STEP after each load.
  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_period <= DEFAULT_PERIOD_P;
      r_update <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_mode   <= '0;
      r_start  <= '0;
      r_end    <= '0;
      r_step   <= '0;
      r_dwell  <= '0;
      r_dir_up <= 1'b0;
    end else begin
      r_update <= 1'b0;
      r_done   <= 1'b0;
      if (cr_stop) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (cr_start) begin
              r_mode   <= cr_mode;
              r_start  <= cr_period_start;
              r_end    <= cr_period_end;
              r_step   <= cr_period_step;
              r_dwell  <= cr_dwell_cycles;
              r_dir_up <= (cr_period_start < cr_period_end);
              r_period <= cr_period_start;
              r_update <= 1'b1;
              r_busy   <= 1'b1;
              r_cnt    <= w_start_reload;
              r_state  <= (w_start_reload == '0) ? ST_STEP : ST_DWELL;
            end
          end
          ST_DWELL: begin
            if (r_cnt <= 1) begin
              r_cnt   <= '0;
              r_state <= ST_STEP;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          ST_STEP: begin
            r_cnt   <= w_reload;
            r_state <= (w_reload == '0) ? ST_STEP : ST_DWELL;
            if (w_at_end) begin
              case (r_mode)
                2'd1: begin
                  r_period <= r_start;
                  r_update <= 1'b1;
                end
                2'd2: begin
                  r_start  <= r_end;
                  r_end    <= r_start;
                  r_dir_up <= ~r_dir_up;
                  r_period <= w_pp_next;
                  r_update <= 1'b1;
                end
                default: begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
                end
              endcase
            end else begin
              r_period <= w_step_next;
              // A zero step leaves the value unchanged: no update pulse.
              r_update <= (w_step_next != r_period);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign period_out    = r_period;
  assign period_update = r_update;
  assign sweep_busy    = r_busy;
  assign sweep_done    = r_done;

endmodule

// File: tb/tb_osc_period_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_osc_period_sweep_ctrl
//   Directed self-checking bench for osc_period_sweep_ctrl. Inputs are driven
//   1ns after the rising edge and outputs are sampled at the same point, so
//   "cycle k" below means the k-th clock after the edge that accepted
//   cr_start.
// ----------------------------------------------------------------------------
module tb_osc_period_sweep_ctrl;

  localparam int CW = 28;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          cr_start;
  logic          cr_stop;
  logic [1:0]    cr_mode;
  logic [CW-1:0] cr_period_start;
  logic [CW-1:0] cr_period_end;
  logic [CW-1:0] cr_period_step;
  logic [DW-1:0] cr_dwell_cycles;
  logic [CW-1:0] period_out;
  logic          period_update;
  logic          sweep_busy;
  logic          sweep_done;

  int errors = 0;
  int checks = 0;

  osc_period_sweep_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cr_start        (cr_start),
    .cr_stop         (cr_stop),
    .cr_mode         (cr_mode),
    .cr_period_start (cr_period_start),
    .cr_period_end   (cr_period_end),
    .cr_period_step  (cr_period_step),
    .cr_dwell_cycles (cr_dwell_cycles),
    .period_out      (period_out),
    .period_update   (period_update),
    .sweep_busy      (sweep_busy),
    .sweep_done      (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] mode, input int ps, input int pe,
                         input int st, input int dw);
    cr_mode         = mode;
    cr_period_start = CW'(ps);
    cr_period_end   = CW'(pe);
    cr_period_step  = CW'(st);
    cr_dwell_cycles = DW'(dw);
  endtask

  task automatic pulse_start();
    cr_start = 1'b1;
    tick();
    cr_start = 1'b0;
  endtask

  task automatic pulse_stop();
    cr_stop = 1'b1;
    tick();
    cr_stop = 1'b0;
  endtask

  task automatic check_all(input string tag, input int p, input logic upd,
                           input logic busy, input logic done);
    check({tag, ".period"}, 32'(period_out), p);
    check({tag, ".update"}, 32'(period_update), 32'(upd));
    check({tag, ".busy"},   32'(sweep_busy), 32'(busy));
    check({tag, ".done"},   32'(sweep_done), 32'(done));
  endtask

  initial begin
    int exp_p;
    int n_upd;
    int pp_seq [4];
    pp_seq = '{5, 7, 9, 7};

    rst_n    = 1'b0;
    cr_start = 1'b0;
    cr_stop  = 1'b0;
    set_cfg(2'd0, 0, 0, 0, 0);
    #12;
    check_all("reset", 1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_all("idle", 1, 1'b0, 1'b0, 1'b0);

    // One-shot up: 10,14,18,20 held 3 clks each, done at cycle 12.
    // A mid-sweep end change and a start-while-busy are both ignored.
    set_cfg(2'd0, 10, 20, 4, 3);
    pulse_start();
    for (int k = 0; k <= 14; k++) begin
      exp_p = (k < 3) ? 10 : (k < 6) ? 14 : (k < 9) ? 18 : 20;
      check_all($sformatf("oneshot[%0d]", k), exp_p,
                (k < 12) && (k % 3 == 0), k < 12, k == 12);
      if (k == 4) begin
        cr_period_end = CW'(50);
        cr_start      = 1'b1;
      end
      tick();
      cr_start = 1'b0;
    end

    // Down sweep with clamp at 1: 100,60,20,1 held 2 clks, done at cycle 8.
    set_cfg(2'd0, 100, 1, 40, 2);
    pulse_start();
    n_upd = 0;
    for (int k = 0; k <= 10; k++) begin
      exp_p = (k < 2) ? 100 : (k < 4) ? 60 : (k < 6) ? 20 : 1;
      check($sformatf("down[%0d].period", k), 32'(period_out), exp_p);
      check($sformatf("down[%0d].done", k), 32'(sweep_done), 32'(k == 8));
      if (period_update) n_upd++;
      tick();
    end
    check("down.update_count", n_upd, 4);
    check("down.busy_after", 32'(sweep_busy), 0);

    // Mode 3 behaves as one-shot: 2, then 3 (clamped), done next cycle.
    set_cfg(2'd3, 2, 3, 5, 1);
    pulse_start();
    check_all("mode3[0]", 2, 1'b1, 1'b1, 1'b0);
    tick();
    check_all("mode3[1]", 3, 1'b1, 1'b1, 1'b0);
    tick();
    check_all("mode3[2]", 3, 1'b0, 1'b0, 1'b1);

    // Ping-pong 5,7,9,7,5,... with dwell 1; stop while showing 7 (cycle 9).
    set_cfg(2'd2, 5, 9, 2, 1);
    pulse_start();
    for (int k = 0; k <= 9; k++) begin
      check_all($sformatf("pingpong[%0d]", k), pp_seq[k % 4], 1'b1, 1'b1, 1'b0);
      if (k < 9) tick();
    end
    pulse_stop();
    check_all("pp_stop", 7, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check_all("pp_stop_hold", 7, 1'b0, 1'b0, 1'b0);

    // Repeat with dwell 0 (behaves as 1): 3,4,5,3,... update every cycle.
    set_cfg(2'd1, 3, 5, 1, 0);
    pulse_start();
    for (int k = 0; k <= 8; k++) begin
      check_all($sformatf("repeat[%0d]", k), 3 + (k % 3), 1'b1, 1'b1, 1'b0);
      if (k < 8) tick();
    end
    pulse_stop();
    check_all("rep_stop", 5, 1'b0, 1'b0, 1'b0);

    // Start and stop together from idle: stop wins.
    set_cfg(2'd0, 40, 60, 5, 2);
    cr_start = 1'b1;
    cr_stop  = 1'b1;
    tick();
    cr_start = 1'b0;
    cr_stop  = 1'b0;
    check_all("start_stop", 5, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("start_stop2", 5, 1'b0, 1'b0, 1'b0);

    // Zero step: period stays at start, single update pulse, stays busy.
    set_cfg(2'd0, 30, 40, 0, 2);
    pulse_start();
    for (int k = 0; k <= 9; k++) begin
      check_all($sformatf("step0[%0d]", k), 30, k == 0, 1'b1, 1'b0);
      tick();
    end
    pulse_stop();
    check_all("step0_stop", 30, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a dwell.
    set_cfg(2'd0, 10, 20, 4, 5);
    pulse_start();
    tick();
    tick();
    check_all("pre_reset", 10, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    check_all("async_reset", 1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_all("post_reset_idle", 1, 1'b0, 1'b0, 1'b0);
    set_cfg(2'd0, 10, 20, 4, 3);
    pulse_start();
    for (int k = 0; k <= 3; k++) begin
      check_all($sformatf("restart[%0d]", k), (k < 3) ? 10 : 14,
                (k % 3) == 0, 1'b1, 1'b0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
